pc_src: RTL and testbench

Next-PC select decoder for the RV32I execute/memory stage. Looks at the instruction in that stage and the branch comparator flags `BrEq`/`BrLt`, and produces the 2-bit `src` select that steers the fetch PC mux. It also produces a registered `kill` pulse so the front end can flush wrong-path instructions after a redirect.

---
 rtl/pc_src_pkg.sv | 22 ++
 rtl/pc_src_branch_cond.sv | 25 ++
 rtl/pc_src.sv | 71 +++++++
 tb/tb_pc_src.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pc_src_pkg.sv
// Shared constants for the next-PC select decoder: opcodes, branch funct3 codes and the
// PC-select encoding.
package pc_src_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [1:0] PCSEL_PC4 = 2'b00;
   localparam logic [1:0] PCSEL_ALU = 2'b01;
   localparam logic [1:0] PCSEL_RST = 2'b10;

endpackage

// File: rtl/pc_src_branch_cond.sv
// Branch condition evaluator: maps a branch funct3 and the comparator flags to taken.
// Purely combinational; reserved funct3 codes (010/011) are never taken.
module pc_src_branch_cond
   import pc_src_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_br_eq,
   input  logic       i_br_lt,
   output logic       o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_funct3)
         F3_BEQ:  o_taken = i_br_eq;
         F3_BNE:  o_taken = ~i_br_eq;
         F3_BLT:  o_taken = i_br_lt;
         F3_BGE:  o_taken = ~i_br_lt;
         F3_BLTU: o_taken = i_br_lt;
         F3_BGEU: o_taken = ~i_br_lt;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_src.sv
// Next-PC select decoder with a registered kill pulse one cycle after any redirect.
// Optional macro PCSRC_STRICT_DECODE_EN tightens JALR funct3 and inst[1:0] checking.
module pc_src
   import pc_src_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        BrEq,
   input  logic        BrLt,
   output logic [1:0]  src,
   output logic        kill
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_taken;
   logic       w_is_jal;
   logic       w_is_jalr;
   logic       w_is_branch;
   logic [1:0] w_src;
   logic       r_kill;
   logic       w_unused_inst;

   assign w_opcode      = inst[6:0];
   assign w_funct3      = inst[14:12];
   assign w_unused_inst = ^{inst[31:15], inst[11:7]};

   pc_src_branch_cond u_branch_cond (
      .i_funct3 (w_funct3),
      .i_br_eq  (BrEq),
      .i_br_lt  (BrLt),
      .o_taken  (w_taken)
   );

`ifdef PCSRC_STRICT_DECODE_EN
   logic w_len32;
   // Redundant with the full opcode compare, but kept explicit as a hard 32-bit guard.
   assign w_len32     = (inst[1:0] == 2'b11);
   assign w_is_jal    = w_len32 && (w_opcode == OPC_JAL);
   assign w_is_jalr   = w_len32 && (w_opcode == OPC_JALR) && (w_funct3 == F3_JALR);
   assign w_is_branch = w_len32 && (w_opcode == OPC_BRANCH);
`else
   assign w_is_jal    = (w_opcode == OPC_JAL);
   assign w_is_jalr   = (w_opcode == OPC_JALR);
   assign w_is_branch = (w_opcode == OPC_BRANCH);
`endif

   always_comb begin
      w_src = PCSEL_PC4;
      if (rst) begin
         w_src = PCSEL_RST;
      end else if (w_is_jal || w_is_jalr) begin
         w_src = PCSEL_ALU;
      end else if (w_is_branch && w_taken) begin
         w_src = PCSEL_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_kill <= 1'b0;
      end else begin
         r_kill <= (w_src == PCSEL_ALU);
      end
   end

   assign src  = w_src;
   assign kill = r_kill;

endmodule

// File: tb/tb_pc_src.sv
// Scoreboard bench for pc_src: directed vectors push expected src/kill into a queue,
// an independent monitor pops and compares on the falling edge.
module tb_pc_src;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = 32'h0;
   logic        BrEq = 1'b0;
   logic        BrLt = 1'b0;
   logic [1:0]  src;
   logic        kill;

   always #5 clk = ~clk;

   pc_src dut (
      .clk  (clk),
      .rst  (rst),
      .inst (inst),
      .BrEq (BrEq),
      .BrLt (BrLt),
      .src  (src),
      .kill (kill)
   );

   typedef struct {
      logic [1:0] src;
      logic       kill;
      bit         chk_kill;
      int         idx;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_n  = 0;
   logic model_kill_next = 1'b0;
   bit   model_known = 1'b0;

   localparam logic [31:0] I_JAL    = 32'h000003ef;
   localparam logic [31:0] I_JALR   = 32'h4d508467;
   localparam logic [31:0] I_JALR1  = 32'h4d509467;
   localparam logic [31:0] I_BEQ    = 32'h08248663;
   localparam logic [31:0] I_BNE    = 32'h08351463;
   localparam logic [31:0] I_BLT    = 32'h0845c263;
   localparam logic [31:0] I_BLTU   = 32'h0666ee63;
   localparam logic [31:0] I_BGE    = 32'h08565063;
   localparam logic [31:0] I_BGEU   = 32'h06777c63;
   localparam logic [31:0] I_B010   = 32'h0824a663;
   localparam logic [31:0] I_B011   = 32'h0824b663;
   localparam logic [31:0] I_LB     = 32'h00840783;
   localparam logic [31:0] I_JAL16  = 32'h000003ed;

`ifdef PCSRC_STRICT_DECODE_EN
   localparam logic [1:0] EXP_JALR1 = 2'b00;
`else
   localparam logic [1:0] EXP_JALR1 = 2'b01;
`endif

   // The kill seen during a cycle is what the previous cycle's src committed at the edge.
   task automatic apply(input logic r, input logic [31:0] i, input logic eq, input logic lt,
                        input logic [1:0] exp_src);
      exp_t e;
      @(posedge clk);
      #1;
      rst  = r;
      inst = i;
      BrEq = eq;
      BrLt = lt;
      e.src      = exp_src;
      e.kill     = model_kill_next;
      e.chk_kill = model_known;
      e.idx      = vec_n;
      sb.push_back(e);
      model_kill_next = r ? 1'b0 : (exp_src == 2'b01);
      model_known     = 1'b1;
      vec_n++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (src !== e.src) begin
               errors++;
               $display("FAIL src vec%0d: got %b expected %b", e.idx, src, e.src);
            end
            if (e.chk_kill) begin
               checks++;
               if (kill !== e.kill) begin
                  errors++;
                  $display("FAIL kill vec%0d: got %b expected %b", e.idx, kill, e.kill);
               end
            end
         end
      end
   end

   initial begin : stimulus
      int waited;
      // reset, then release with inst=0 and flags ignored
      apply(1'b1, 32'h0, 1'b0, 1'b0, 2'b10);
      apply(1'b1, 32'h0, 1'b0, 1'b0, 2'b10);
      apply(1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
      apply(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      // jumps regardless of flags, back-to-back kill
      apply(1'b0, I_JAL,  1'b0, 1'b0, 2'b01);
      apply(1'b0, I_JALR, 1'b1, 1'b1, 2'b01);
      apply(1'b0, I_JAL,  1'b1, 1'b0, 2'b01);
      apply(1'b0, 32'h0,  1'b0, 1'b0, 2'b00);
      apply(1'b0, 32'h0,  1'b0, 1'b0, 2'b00);
      // BEQ / BNE
      apply(1'b0, I_BEQ, 1'b1, 1'b0, 2'b01);
      apply(1'b0, I_BEQ, 1'b0, 1'b0, 2'b00);
      apply(1'b0, I_BEQ, 1'b0, 1'b1, 2'b00);
      apply(1'b0, I_BNE, 1'b1, 1'b0, 2'b00);
      apply(1'b0, I_BNE, 1'b0, 1'b0, 2'b01);
      apply(1'b0, I_BNE, 1'b0, 1'b1, 2'b01);
      // BLT / BLTU taken only on BrLt
      apply(1'b0, I_BLT,  1'b1, 1'b0, 2'b00);
      apply(1'b0, I_BLT,  1'b0, 1'b1, 2'b01);
      apply(1'b0, I_BLT,  1'b0, 1'b0, 2'b00);
      apply(1'b0, I_BLTU, 1'b1, 1'b0, 2'b00);
      apply(1'b0, I_BLTU, 1'b0, 1'b1, 2'b01);
      apply(1'b0, I_BLTU, 1'b0, 1'b0, 2'b00);
      // BGE / BGEU taken only on !BrLt
      apply(1'b0, I_BGE,  1'b1, 1'b0, 2'b01);
      apply(1'b0, I_BGE,  1'b0, 1'b1, 2'b00);
      apply(1'b0, I_BGE,  1'b0, 1'b0, 2'b01);
      apply(1'b0, I_BGEU, 1'b1, 1'b0, 2'b01);
      apply(1'b0, I_BGEU, 1'b0, 1'b1, 2'b00);
      apply(1'b0, I_BGEU, 1'b0, 1'b0, 2'b01);
      // both flags set, reserved branch funct3, loads, compressed-looking encodings
      apply(1'b0, I_BEQ,   1'b1, 1'b1, 2'b01);
      apply(1'b0, I_B010,  1'b1, 1'b1, 2'b00);
      apply(1'b0, I_B011,  1'b0, 1'b0, 2'b00);
      apply(1'b0, I_LB,    1'b1, 1'b1, 2'b00);
      apply(1'b0, I_LB,    1'b1, 1'b0, 2'b00);
      apply(1'b0, I_LB,    1'b0, 1'b1, 2'b00);
      apply(1'b0, I_JAL16, 1'b0, 1'b0, 2'b00);
      apply(1'b0, I_JALR1, 1'b0, 1'b0, EXP_JALR1);
      apply(1'b0, 32'h0,   1'b0, 1'b0, 2'b00);
      // reset overrides a redirect and clears kill at the next edge
      apply(1'b0, I_JAL, 1'b0, 1'b0, 2'b01);
      apply(1'b1, I_JAL, 1'b0, 1'b0, 2'b10);
      apply(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
      apply(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);

      waited = 0;
      while (sb.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
